axis_multiport_tx_checker: RTL and testbench

Parametrised, self-checking AXI4-Stream transmit checker for the rldram_stream tx benches. It generalises the single fixed port-set checker to C_NUM_PORTS passive output taps of configurable width. Expected packets, taken from the DMA stimulus stream, are routed by their one-hot destination bits into per-port expected FIFOs. Observed egress packets are compared beat by beat, with per-port pass/fail counters and a first-error capture.

---
 rtl/axis_multiport_tx_checker.sv | 239 +++++++++++++++++++++++
 tb/tb_axis_multiport_tx_checker.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_multiport_tx_checker.sv
// rtl/axis_multiport_tx_checker.sv - multi-port AXI4-Stream egress checker fed by routed expected FIFOs
// Build option CHECKER_KEEP_MASK_EN: compare tdata only on byte lanes kept by the expected beat.
module axis_multiport_tx_checker #(
  parameter int C_DATA_WIDTH = 256,
  parameter int C_USER_WIDTH = 128,
  parameter int C_NUM_PORTS  = 4,
  parameter int C_EXP_DEPTH  = 64,
  parameter int C_DST_POS    = 24
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic [C_DATA_WIDTH-1:0]               s_axis_exp_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]             s_axis_exp_tkeep,
  input  logic [C_USER_WIDTH-1:0]               s_axis_exp_tuser,
  input  logic                                  s_axis_exp_tvalid,
  input  logic                                  s_axis_exp_tlast,
  output logic                                  s_axis_exp_tready,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]   obs_tdata,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH/8-1:0] obs_tkeep,
  input  logic [C_NUM_PORTS-1:0]                obs_tvalid,
  input  logic [C_NUM_PORTS-1:0]                obs_tready,
  input  logic [C_NUM_PORTS-1:0]                obs_tlast,
  output logic [C_NUM_PORTS*32-1:0]             pkt_ok_cnt,
  output logic [C_NUM_PORTS*32-1:0]             pkt_err_cnt,
  output logic [C_NUM_PORTS*32-1:0]             unexp_cnt,
  output logic [31:0]                           drop_cnt,
  output logic                                  err_sticky,
  output logic [2:0]                            first_err_port,
  output logic                                  all_idle
);
  localparam int KW = C_DATA_WIDTH / 8;
  localparam int EW = C_DATA_WIDTH + KW + 1;
  localparam int AW = (C_EXP_DEPTH > 1) ? $clog2(C_EXP_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_FLUSH, S_DROP} state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic                   r_reset_d;
  logic                   r_in_pkt;
  logic [C_NUM_PORTS-1:0] r_mask;
  logic [31:0]            r_drop_cnt;
  logic                   r_err_sticky;
  logic [2:0]             r_first_err;

  logic [C_NUM_PORTS-1:0] w_live_mask;
  logic [C_NUM_PORTS-1:0] w_mask;
  logic [C_NUM_PORTS-1:0] w_full;
  logic [C_NUM_PORTS-1:0] w_push;
  logic [C_NUM_PORTS-1:0] w_idle;
  logic [C_NUM_PORTS-1:0] w_pkt_err;
  logic [C_NUM_PORTS-1:0] w_unexp;
  logic [C_NUM_PORTS-1:0] w_any_err;
  logic [2:0]             w_first_port;
  logic                   w_acc;
  logic                   w_drop;
  logic                   w_unused;

  assign w_unused = ^s_axis_exp_tuser;

  for (genvar g = 0; g < C_NUM_PORTS; g++) begin : g_dst
    assign w_live_mask[g] = s_axis_exp_tuser[C_DST_POS + 2*g];
  end

  // Mid-packet the mask comes from the first beat; later tuser values are ignored.
  assign w_mask            = r_in_pkt ? r_mask : w_live_mask;
  assign s_axis_exp_tready = !RESET && !r_reset_d && ((w_mask & w_full) == '0);
  assign w_acc             = s_axis_exp_tvalid && s_axis_exp_tready;
  assign w_push            = w_acc ? w_mask : '0;
  assign w_drop            = w_acc && s_axis_exp_tlast && (w_mask == '0);

  for (genvar g = 0; g < C_NUM_PORTS; g++) begin : g_port
    logic [EW-1:0]           r_mem [C_EXP_DEPTH];
    logic [AW:0]             r_wr;
    logic [AW:0]             r_rd;
    state_t                  r_state;
    logic                    r_bad;
    logic [31:0]             r_ok;
    logic [31:0]             r_err;
    logic [31:0]             r_unexp;
    logic [EW-1:0]           w_head;
    logic [C_DATA_WIDTH-1:0] w_exp_data;
    logic [KW-1:0]           w_exp_keep;
    logic                    w_exp_last;
    logic [C_DATA_WIDTH-1:0] w_obs_data;
    logic [KW-1:0]           w_obs_keep;
    logic                    w_obs_last;
    logic                    w_beat;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_data_mis;
    logic                    w_mis;
    logic                    w_bad_now;
    logic                    w_ok_evt;
    logic                    w_err_evt;
    logic                    w_unexp_evt;

    assign w_head = r_mem[r_rd[AW-1:0]];
    assign {w_exp_data, w_exp_keep, w_exp_last} = w_head;
    assign w_obs_data = obs_tdata[g*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign w_obs_keep = obs_tkeep[g*KW +: KW];
    assign w_obs_last = obs_tlast[g];
    assign w_beat     = obs_tvalid[g] && obs_tready[g];
    assign w_empty    = (r_wr == r_rd);
    assign w_full[g]  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_idle[g]  = w_empty && (r_state == S_IDLE);

`ifdef CHECKER_KEEP_MASK_EN
    always_comb begin
      w_data_mis = 1'b0;
      for (int b = 0; b < KW; b++) begin
        if (w_exp_keep[b] && (w_exp_data[8*b +: 8] != w_obs_data[8*b +: 8])) w_data_mis = 1'b1;
      end
    end
`else
    assign w_data_mis = (w_exp_data != w_obs_data);
`endif

    assign w_mis     = w_data_mis || (w_exp_keep != w_obs_keep) || (w_exp_last != w_obs_last);
    assign w_bad_now = w_mis || ((r_state == S_CMP) && r_bad);
    assign w_pop     = !w_empty && ((r_state == S_FLUSH) ||
                       (w_beat && ((r_state == S_IDLE) || (r_state == S_CMP))));

    always_comb begin
      w_ok_evt    = 1'b0;
      w_err_evt   = 1'b0;
      w_unexp_evt = 1'b0;
      case (r_state)
        S_IDLE, S_CMP: begin
          if (w_beat) begin
            if (w_empty) begin
              w_unexp_evt = 1'b1;
              w_err_evt   = (r_state == S_CMP) && w_obs_last;
            end else if (w_exp_last || w_obs_last) begin
              w_ok_evt  = w_exp_last && w_obs_last && !w_bad_now;
              w_err_evt = !(w_exp_last && w_obs_last && !w_bad_now);
            end
          end
        end
        S_FLUSH: w_unexp_evt = w_beat;
        default: ;
      endcase
    end

    assign w_pkt_err[g] = w_err_evt;
    assign w_unexp[g]   = w_unexp_evt;

    always_ff @(posedge CLK) begin
      if (w_push[g]) r_mem[r_wr[AW-1:0]] <= {s_axis_exp_tdata, s_axis_exp_tkeep, s_axis_exp_tlast};
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        r_wr    <= '0;
        r_rd    <= '0;
        r_state <= S_IDLE;
        r_bad   <= 1'b0;
        r_ok    <= '0;
        r_err   <= '0;
        r_unexp <= '0;
      end else begin
        if (w_push[g])   r_wr    <= r_wr + 1'b1;
        if (w_pop)       r_rd    <= r_rd + 1'b1;
        if (w_ok_evt)    r_ok    <= sat_inc(r_ok);
        if (w_err_evt)   r_err   <= sat_inc(r_err);
        if (w_unexp_evt) r_unexp <= sat_inc(r_unexp);
        case (r_state)
          S_IDLE, S_CMP: begin
            if (w_beat) begin
              if (w_empty) begin
                // Starved mid-packet: the packet is already bad, keep comparing what arrives.
                if (r_state == S_IDLE) begin
                  r_state <= w_obs_last ? S_IDLE : S_DROP;
                end else begin
                  r_bad <= 1'b1;
                  if (w_obs_last) r_state <= S_FLUSH;
                end
              end else if (w_exp_last && w_obs_last) begin
                r_state <= S_IDLE;
              end else if (w_obs_last) begin
                r_state <= S_FLUSH;
              end else if (w_exp_last) begin
                r_state <= S_DROP;
              end else begin
                r_state <= S_CMP;
                r_bad   <= w_bad_now;
              end
            end
          end
          S_FLUSH: if (w_pop && w_exp_last) r_state <= S_IDLE;
          default: if (w_beat && w_obs_last) r_state <= S_IDLE;
        endcase
      end
    end

    assign pkt_ok_cnt[g*32 +: 32]  = RESET ? 32'd0 : r_ok;
    assign pkt_err_cnt[g*32 +: 32] = RESET ? 32'd0 : r_err;
    assign unexp_cnt[g*32 +: 32]   = RESET ? 32'd0 : r_unexp;
  end

  assign w_any_err = w_pkt_err | w_unexp;

  always_comb begin
    w_first_port = 3'd0;
    for (int p = C_NUM_PORTS - 1; p >= 0; p--) begin
      if (w_any_err[p]) w_first_port = 3'(p);
    end
  end

  always_ff @(posedge CLK) begin
    r_reset_d <= RESET;
    if (RESET) begin
      r_in_pkt     <= 1'b0;
      r_mask       <= '0;
      r_drop_cnt   <= '0;
      r_err_sticky <= 1'b0;
      r_first_err  <= 3'd0;
    end else begin
      if (w_acc) begin
        r_in_pkt <= !s_axis_exp_tlast;
        if (!r_in_pkt) r_mask <= w_live_mask;
      end
      if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
      // Port errors outrank a drop landing in the same cycle.
      if (!r_err_sticky && ((w_any_err != '0) || w_drop)) begin
        r_err_sticky <= 1'b1;
        r_first_err  <= (w_any_err != '0) ? w_first_port : 3'd7;
      end
    end
  end

  assign drop_cnt       = RESET ? 32'd0 : r_drop_cnt;
  assign err_sticky     = !RESET && r_err_sticky;
  assign first_err_port = RESET ? 3'd0 : r_first_err;
  assign all_idle       = !RESET && (&w_idle);

endmodule

// File: tb/tb_axis_multiport_tx_checker.sv
// tb/tb_axis_multiport_tx_checker.sv - self-checking bench for axis_multiport_tx_checker
// Honours CHECKER_KEEP_MASK_EN in its reference model.
module tb_axis_multiport_tx_checker;
  localparam int DW = 256, KW = 32, UW = 128, NP = 4, DEPTH = 64, DPOS = 24;

  logic CLK = 1'b0;
  logic RESET;
  logic [DW-1:0] exp_tdata;
  logic [KW-1:0] exp_tkeep;
  logic [UW-1:0] exp_tuser;
  logic exp_tvalid, exp_tlast, exp_tready;
  logic [NP*DW-1:0] obs_tdata;
  logic [NP*KW-1:0] obs_tkeep;
  logic [NP-1:0] obs_tvalid, obs_tready, obs_tlast;
  logic [NP*32-1:0] pkt_ok_cnt, pkt_err_cnt, unexp_cnt;
  logic [31:0] drop_cnt;
  logic err_sticky;
  logic [2:0] first_err_port;
  logic all_idle;

  int total = 0;
  int bad = 0;

  typedef struct { logic [DW-1:0] d; logic [KW-1:0] k; } beat_t;
  beat_t pkt_q[$];

  always #5 CLK = ~CLK;

  axis_multiport_tx_checker #(
    .C_DATA_WIDTH(DW), .C_USER_WIDTH(UW), .C_NUM_PORTS(NP), .C_EXP_DEPTH(DEPTH), .C_DST_POS(DPOS)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .s_axis_exp_tdata(exp_tdata), .s_axis_exp_tkeep(exp_tkeep), .s_axis_exp_tuser(exp_tuser),
    .s_axis_exp_tvalid(exp_tvalid), .s_axis_exp_tlast(exp_tlast), .s_axis_exp_tready(exp_tready),
    .obs_tdata(obs_tdata), .obs_tkeep(obs_tkeep), .obs_tvalid(obs_tvalid), .obs_tready(obs_tready),
    .obs_tlast(obs_tlast), .pkt_ok_cnt(pkt_ok_cnt), .pkt_err_cnt(pkt_err_cnt), .unexp_cnt(unexp_cnt),
    .drop_cnt(drop_cnt), .err_sticky(err_sticky), .first_err_port(first_err_port), .all_idle(all_idle)
  );

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic make_pkt(input int len, input logic [KW-1:0] last_keep);
    beat_t b;
    pkt_q.delete();
    for (int i = 0; i < len; i++) begin
      b.d = rand_dw();
      b.k = (i == len - 1) ? last_keep : '1;
      pkt_q.push_back(b);
    end
  endtask

  task automatic idle_inputs();
    exp_tvalid = 0; exp_tlast = 0; exp_tdata = '0; exp_tkeep = '0; exp_tuser = '0;
    obs_tvalid = '0; obs_tready = '0; obs_tlast = '0; obs_tdata = '0; obs_tkeep = '0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1;
    idle_inputs();
    repeat (3) @(posedge CLK);
    #1 RESET = 0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic send_exp(input logic [NP-1:0] mask, input int nb);
    bit acc;
    int guard;
    for (int i = 0; i < nb && i < pkt_q.size(); i++) begin
      exp_tdata = pkt_q[i].d;
      exp_tkeep = pkt_q[i].k;
      exp_tlast = (i == pkt_q.size() - 1);
      exp_tuser = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) for (int p = 0; p < NP; p++) exp_tuser[DPOS + 2*p] = mask[p];
      exp_tvalid = 1;
      guard = 0;
      do begin
        @(negedge CLK);
        acc = exp_tready;
        @(posedge CLK); #1;
        guard++;
      end while (!acc && guard < 200);
      if (!acc) begin
        total++; bad++;
        $display("FAIL exp_accept_timeout beat=%0d tready=%0b required=1", i, exp_tready);
        exp_tvalid = 0;
        return;
      end
    end
    exp_tvalid = 0;
  endtask

  task automatic send_obs(input int p, input bit stall);
    for (int i = 0; i < pkt_q.size(); i++) begin
      obs_tdata[p*DW +: DW] = pkt_q[i].d;
      obs_tkeep[p*KW +: KW] = pkt_q[i].k;
      obs_tlast[p] = (i == pkt_q.size() - 1);
      if (stall) begin
        int n;
        n = $urandom_range(0, 2);
        for (int s = 0; s < n; s++) begin
          obs_tvalid[p] = 1'($urandom_range(0, 1));
          obs_tready[p] = !obs_tvalid[p];
          @(posedge CLK); #1;
        end
      end
      obs_tvalid[p] = 1; obs_tready[p] = 1;
      @(posedge CLK); #1;
    end
    obs_tvalid[p] = 0; obs_tready[p] = 0; obs_tlast[p] = 0;
  endtask

  task automatic test_reset();
    RESET = 1;
    idle_inputs();
    repeat (3) @(posedge CLK);
    #1;
    total++; if (exp_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%0b want=0", exp_tready); end
    total++; if (pkt_ok_cnt !== '0 || pkt_err_cnt !== '0 || unexp_cnt !== '0) begin bad++; $display("FAIL rst_port_cnts ok=%0h err=%0h unexp=%0h want=0", pkt_ok_cnt, pkt_err_cnt, unexp_cnt); end
    total++; if (drop_cnt !== 32'd0 || err_sticky !== 1'b0 || first_err_port !== 3'd0 || all_idle !== 1'b0) begin bad++; $display("FAIL rst_misc drop=%0d sticky=%0b first=%0d idle=%0b want=0/0/0/0", drop_cnt, err_sticky, first_err_port, all_idle); end
    RESET = 0;
    @(negedge CLK);
    total++; if (exp_tready !== 1'b0) begin bad++; $display("FAIL rst_release_tready got=%0b want=0", exp_tready); end
    @(negedge CLK);
    total++; if (exp_tready !== 1'b1) begin bad++; $display("FAIL rst_tready_rise got=%0b want=1", exp_tready); end
    total++; if (all_idle !== 1'b1) begin bad++; $display("FAIL rst_all_idle got=%0b want=1", all_idle); end
    @(posedge CLK); #1;
    make_pkt(3, '1);
    send_exp(4'b0001, 2);
    RESET = 1;
    repeat (2) @(posedge CLK);
    #1 RESET = 0;
    repeat (2) @(posedge CLK);
    #1;
    make_pkt(1, '1);
    send_exp(4'b0001, 1);
    send_obs(0, 0);
    repeat (4) @(posedge CLK);
    #1;
    total++; if (pkt_ok_cnt[31:0] !== 32'd1 || pkt_err_cnt[31:0] !== 32'd0 || unexp_cnt[31:0] !== 32'd0) begin bad++; $display("FAIL rst_midpkt ok=%0d err=%0d unexp=%0d want=1/0/0", pkt_ok_cnt[31:0], pkt_err_cnt[31:0], unexp_cnt[31:0]); end
  endtask

  task automatic test_single_ok();
    do_reset();
    make_pkt(3, '1);
    send_exp(4'b0010, 3);
    send_obs(1, 1);
    repeat (5) @(posedge CLK);
    #1;
    for (int p = 0; p < NP; p++) begin
      total++;
      if (pkt_ok_cnt[p*32 +: 32] !== ((p == 1) ? 32'd1 : 32'd0) || pkt_err_cnt[p*32 +: 32] !== 32'd0 || unexp_cnt[p*32 +: 32] !== 32'd0) begin
        bad++; $display("FAIL single_ok port=%0d ok=%0d err=%0d unexp=%0d want ok=%0d err=0 unexp=0", p, pkt_ok_cnt[p*32 +: 32], pkt_err_cnt[p*32 +: 32], unexp_cnt[p*32 +: 32], (p == 1));
      end
    end
    total++; if (err_sticky !== 1'b0 || all_idle !== 1'b1) begin bad++; $display("FAIL single_ok_flags sticky=%0b idle=%0b want=0/1", err_sticky, all_idle); end
  endtask

  task automatic test_data_err();
    beat_t b;
    do_reset();
    make_pkt(2, '1);
    send_exp(4'b0001, 2);
    b = pkt_q[1];
    b.d[0] = ~b.d[0];
    pkt_q[1] = b;
    send_obs(0, 0);
    repeat (4) @(posedge CLK);
    #1;
    total++; if (pkt_err_cnt[31:0] !== 32'd1 || pkt_ok_cnt[31:0] !== 32'd0) begin bad++; $display("FAIL data_err ok=%0d err=%0d want=0/1", pkt_ok_cnt[31:0], pkt_err_cnt[31:0]); end
    total++; if (err_sticky !== 1'b1 || first_err_port !== 3'd0) begin bad++; $display("FAIL data_err_first sticky=%0b port=%0d want=1/0", err_sticky, first_err_port); end
  endtask

  task automatic test_early_last();
    do_reset();
    make_pkt(4, '1);
    send_exp(4'b0100, 4);
    void'(pkt_q.pop_back());
    void'(pkt_q.pop_back());
    send_obs(2, 0);
    repeat (6) @(posedge CLK);
    #1;
    total++; if (pkt_err_cnt[64 +: 32] !== 32'd1 || first_err_port !== 3'd2) begin bad++; $display("FAIL early_last err=%0d first=%0d want=1/2", pkt_err_cnt[64 +: 32], first_err_port); end
    total++; if (all_idle !== 1'b1) begin bad++; $display("FAIL early_last_flush idle=%0b want=1", all_idle); end
    make_pkt(2, 32'h0000_00FF);
    send_exp(4'b0100, 2);
    send_obs(2, 1);
    repeat (4) @(posedge CLK);
    #1;
    total++; if (pkt_ok_cnt[64 +: 32] !== 32'd1 || pkt_err_cnt[64 +: 32] !== 32'd1 || unexp_cnt[64 +: 32] !== 32'd0) begin bad++; $display("FAIL early_last_next ok=%0d err=%0d unexp=%0d want=1/1/0", pkt_ok_cnt[64 +: 32], pkt_err_cnt[64 +: 32], unexp_cnt[64 +: 32]); end
  endtask

  task automatic test_full();
    beat_t b1;
    do_reset();
    make_pkt(DEPTH, '1);
    send_exp(4'b1111, DEPTH);
    b1.d = rand_dw(); b1.k = '1;
    exp_tdata = b1.d; exp_tkeep = b1.k; exp_tlast = 1;
    exp_tuser = '0;
    for (int p = 0; p < NP; p++) exp_tuser[DPOS + 2*p] = 1'b1;
    exp_tvalid = 1;
    for (int p = 0; p < NP; p++) begin
      obs_tdata[p*DW +: DW] = pkt_q[0].d;
      obs_tkeep[p*KW +: KW] = pkt_q[0].k;
    end
    obs_tlast = '0; obs_tvalid = '1; obs_tready = '1;
    @(negedge CLK);
    total++; if (exp_tready !== 1'b0) begin bad++; $display("FAIL full_tready got=%0b want=0", exp_tready); end
    @(posedge CLK); #1;
    obs_tvalid = '0; obs_tready = '0;
    @(negedge CLK);
    total++; if (exp_tready !== 1'b1) begin bad++; $display("FAIL full_restore got=%0b want=1", exp_tready); end
    @(posedge CLK); #1;
    exp_tvalid = 0;
    void'(pkt_q.pop_front());
    for (int p = 0; p < NP; p++) send_obs(p, 0);
    pkt_q.delete();
    pkt_q.push_back(b1);
    for (int p = 0; p < NP; p++) send_obs(p, 0);
    repeat (4) @(posedge CLK);
    #1;
    for (int p = 0; p < NP; p++) begin
      total++;
      if (pkt_ok_cnt[p*32 +: 32] !== 32'd2 || pkt_err_cnt[p*32 +: 32] !== 32'd0) begin
        bad++; $display("FAIL full_drain port=%0d ok=%0d err=%0d want=2/0", p, pkt_ok_cnt[p*32 +: 32], pkt_err_cnt[p*32 +: 32]);
      end
    end
    total++; if (all_idle !== 1'b1 || err_sticky !== 1'b0) begin bad++; $display("FAIL full_idle idle=%0b sticky=%0b want=1/0", all_idle, err_sticky); end
  endtask

  task automatic test_unexp_drop();
    do_reset();
    make_pkt(1, '1);
    send_obs(3, 0);
    repeat (3) @(posedge CLK);
    #1;
    total++; if (unexp_cnt !== {32'd1, 32'd0, 32'd0, 32'd0}) begin bad++; $display("FAIL unexp_cnt got=%0h want port3=1", unexp_cnt); end
    total++; if (err_sticky !== 1'b1 || first_err_port !== 3'd3) begin bad++; $display("FAIL unexp_first sticky=%0b port=%0d want=1/3", err_sticky, first_err_port); end
    make_pkt(2, '1);
    send_exp(4'b0000, 2);
    repeat (3) @(posedge CLK);
    #1;
    total++; if (drop_cnt !== 32'd1 || first_err_port !== 3'd3) begin bad++; $display("FAIL drop_cnt drop=%0d first=%0d want=1/3", drop_cnt, first_err_port); end
    do_reset();
    obs_tlast = 4'b0110; obs_tvalid = 4'b0110; obs_tready = 4'b0110;
    @(posedge CLK); #1;
    obs_tlast = '0; obs_tvalid = '0; obs_tready = '0;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (first_err_port !== 3'd1 || unexp_cnt !== {32'd0, 32'd1, 32'd1, 32'd0}) begin bad++; $display("FAIL tie_first port=%0d unexp=%0h want port=1", first_err_port, unexp_cnt); end
    do_reset();
    make_pkt(1, '1);
    send_exp(4'b0000, 1);
    repeat (2) @(posedge CLK);
    #1;
    total++; if (first_err_port !== 3'd7 || err_sticky !== 1'b1 || drop_cnt !== 32'd1) begin bad++; $display("FAIL drop_first port=%0d sticky=%0b drop=%0d want=7/1/1", first_err_port, err_sticky, drop_cnt); end
  endtask

  task automatic test_keep_mask();
    beat_t b;
    do_reset();
    make_pkt(2, 32'h0000_FFFF);
    send_exp(4'b0001, 2);
    b = pkt_q[1];
    b.d[DW-1:DW/2] = ~b.d[DW-1:DW/2];
    pkt_q[1] = b;
    send_obs(0, 0);
    repeat (4) @(posedge CLK);
    #1;
`ifdef CHECKER_KEEP_MASK_EN
    total++; if (pkt_ok_cnt[31:0] !== 32'd1 || pkt_err_cnt[31:0] !== 32'd0) begin bad++; $display("FAIL keep_mask ok=%0d err=%0d want=1/0", pkt_ok_cnt[31:0], pkt_err_cnt[31:0]); end
`else
    total++; if (pkt_ok_cnt[31:0] !== 32'd0 || pkt_err_cnt[31:0] !== 32'd1) begin bad++; $display("FAIL keep_mask ok=%0d err=%0d want=0/1", pkt_ok_cnt[31:0], pkt_err_cnt[31:0]); end
`endif
  endtask

  task automatic test_random();
    logic [DW-1:0] pd [12][4];
    logic [KW-1:0] pk [12][4];
    int plen [12];
    logic [NP-1:0] pmask [12];
    int m_ok [NP];
    int m_err [NP];
    int m_unexp [NP];
    int m_drop, m_first, mode, bi, bit_i, n;
    bit good;
    beat_t b;
    do_reset();
    m_drop = 0; m_first = -1;
    for (int p = 0; p < NP; p++) begin m_ok[p] = 0; m_err[p] = 0; m_unexp[p] = 0; end
    for (int i = 0; i < 12; i++) begin
      plen[i] = $urandom_range(1, 4);
      pmask[i] = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      pkt_q.delete();
      for (int j = 0; j < plen[i]; j++) begin
        pd[i][j] = rand_dw();
        pk[i][j] = (j == plen[i] - 1) ? ($urandom | 32'h1) : '1;
        b.d = pd[i][j]; b.k = pk[i][j];
        pkt_q.push_back(b);
      end
      send_exp(pmask[i], plen[i]);
      if (pmask[i] == '0) begin m_drop++; if (m_first < 0) m_first = 7; end
    end
    repeat (3) @(posedge CLK);
    #1;
    for (int p = 0; p < NP; p++) begin
      for (int i = 0; i < 12; i++) begin
        if (pmask[i][p]) begin
          pkt_q.delete();
          for (int j = 0; j < plen[i]; j++) begin b.d = pd[i][j]; b.k = pk[i][j]; pkt_q.push_back(b); end
          mode = $urandom_range(0, 4);
          if (mode == 2 && plen[i] == 1) mode = 1;
          bi = $urandom_range(0, plen[i] - 1);
          case (mode)
            1: begin bit_i = $urandom_range(0, DW - 1); b = pkt_q[bi]; b.d[bit_i] = ~b.d[bit_i]; pkt_q[bi] = b; end
            2: begin n = $urandom_range(1, plen[i] - 1); while (pkt_q.size() > n) void'(pkt_q.pop_back()); end
            3: begin b.d = rand_dw(); b.k = '1; pkt_q.push_back(b); end
            4: begin bit_i = $urandom_range(0, KW - 1); b = pkt_q[bi]; b.k[bit_i] = ~b.k[bit_i]; pkt_q[bi] = b; end
            default: ;
          endcase
          good = (pkt_q.size() == plen[i]);
          if (good) begin
            for (int j = 0; j < plen[i]; j++) begin
              if (pkt_q[j].k != pk[i][j]) good = 0;
              for (int l = 0; l < KW; l++) begin
`ifdef CHECKER_KEEP_MASK_EN
                if (pk[i][j][l] && (pkt_q[j].d[8*l +: 8] != pd[i][j][8*l +: 8])) good = 0;
`else
                if (pkt_q[j].d[8*l +: 8] != pd[i][j][8*l +: 8]) good = 0;
`endif
              end
            end
          end
          if (good) m_ok[p]++;
          else begin m_err[p]++; if (m_first < 0) m_first = p; end
          send_obs(p, 1);
          repeat (8) @(posedge CLK);
          #1;
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        make_pkt($urandom_range(1, 2), '1);
        m_unexp[p]++;
        if (m_first < 0) m_first = p;
        send_obs(p, 1);
        repeat (4) @(posedge CLK);
        #1;
      end
    end
    repeat (4) @(posedge CLK);
    #1;
    for (int p = 0; p < NP; p++) begin
      total++;
      if (pkt_ok_cnt[p*32 +: 32] !== 32'(m_ok[p]) || pkt_err_cnt[p*32 +: 32] !== 32'(m_err[p]) || unexp_cnt[p*32 +: 32] !== 32'(m_unexp[p])) begin
        bad++; $display("FAIL rand_port port=%0d ok=%0d err=%0d unexp=%0d want %0d/%0d/%0d", p, pkt_ok_cnt[p*32 +: 32], pkt_err_cnt[p*32 +: 32], unexp_cnt[p*32 +: 32], m_ok[p], m_err[p], m_unexp[p]);
      end
    end
    total++; if (drop_cnt !== 32'(m_drop)) begin bad++; $display("FAIL rand_drop got=%0d want=%0d", drop_cnt, m_drop); end
    total++;
    if (err_sticky !== (m_first >= 0) || first_err_port !== ((m_first < 0) ? 3'd0 : 3'(m_first))) begin
      bad++; $display("FAIL rand_first sticky=%0b port=%0d want_port=%0d", err_sticky, first_err_port, m_first);
    end
    total++; if (all_idle !== 1'b1) begin bad++; $display("FAIL rand_idle got=%0b want=1", all_idle); end
  endtask

  initial begin
    test_reset();
    test_single_ok();
    test_data_err();
    test_early_last();
    test_full();
    test_unexp_drop();
    test_keep_mask();
    for (int r = 0; r < 3; r++) test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time=%0t limit=500000", $time);
    $fatal(1, "watchdog");
  end

endmodule
